bottle_fill_control_module: RTL and testbench

- Downstream consumer of the target-setting stage. Takes the operator's 6-bit target bottle count and pills-per-bottle count and runs the fill sequence.
- Counts pill-sensor events into the current bottle, advances bottles, and reports completion.
- Drives the state code and counters shown by the display stage: s_zero / s_operation / s_report, plus a pause state.

---
 rtl/bottle_fill_control_module.sv | 138 +++++++++++++
 tb/tb_bottle_fill_control_module.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bottle_fill_control_module.sv
// Bottle fill sequencer: counts pill-sensor edges into bottles against latched
// targets and reports state and counters for the display stage.
module bottle_fill_control_module #(
    parameter int CNT_W = 6,
    parameter int TOT_W = 12
) (
    input  logic             in_CLK,
    input  logic             in_RST,
    input  logic             in_start,
    input  logic             in_pill_pulse,
    input  logic             in_display_setting,
    input  logic [CNT_W-1:0] in_target_bottle_num,
    input  logic [CNT_W-1:0] in_target_pill_num,
    output logic [1:0]       out_state,
    output logic [CNT_W-1:0] out_pill_in_bottle,
    output logic [CNT_W-1:0] out_bottle_done,
    output logic [TOT_W-1:0] out_total_pills,
    output logic             out_bottle_change,
    output logic             out_alarm
);

    typedef enum logic [1:0] {
        S_ZERO      = 2'b00,
        S_OPERATION = 2'b01,
        S_PAUSE     = 2'b10,
        S_REPORT    = 2'b11
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic             r_prev_start, r_prev_pill;
    logic [CNT_W-1:0] r_tgt_bottle, w_tgt_bottle_nxt;
    logic [CNT_W-1:0] r_tgt_pill,   w_tgt_pill_nxt;
    logic [CNT_W-1:0] r_pill,       w_pill_nxt;
    logic [CNT_W-1:0] r_bottle,     w_bottle_nxt;
    logic [TOT_W-1:0] r_total,      w_total_nxt;
    logic             r_change,     w_change_nxt;
    logic             r_alarm,      w_alarm_nxt;

    logic             w_start_edge, w_pill_edge;
    logic [CNT_W-1:0] w_pill_inc,   w_bottle_inc;

    assign w_start_edge = in_start & ~r_prev_start;
    assign w_pill_edge  = in_pill_pulse & ~r_prev_pill;
    assign w_pill_inc   = r_pill + CNT_W'(1);
    assign w_bottle_inc = r_bottle + CNT_W'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_tgt_bottle_nxt = r_tgt_bottle;
        w_tgt_pill_nxt   = r_tgt_pill;
        w_pill_nxt       = r_pill;
        w_bottle_nxt     = r_bottle;
        w_total_nxt      = r_total;
        w_change_nxt     = 1'b0;
        w_alarm_nxt      = r_alarm;
        case (r_state)
            S_ZERO: begin
                if (w_start_edge) begin
                    if (in_target_bottle_num != '0 && in_target_pill_num != '0) begin
                        w_tgt_bottle_nxt = in_target_bottle_num;
                        w_tgt_pill_nxt   = in_target_pill_num;
                        w_pill_nxt       = '0;
                        w_bottle_nxt     = '0;
                        w_total_nxt      = '0;
                        w_alarm_nxt      = 1'b0;
                        w_state_nxt      = S_OPERATION;
                    end else begin
                        w_alarm_nxt = 1'b1;
                    end
                end
            end
            S_OPERATION: begin
                // Entering setting mode takes priority over a coincident pill.
                if (in_display_setting) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_pill_edge) begin
                    w_total_nxt = r_total + TOT_W'(1);
                    if (w_pill_inc == r_tgt_pill) begin
                        w_pill_nxt   = '0;
                        w_bottle_nxt = w_bottle_inc;
                        w_change_nxt = 1'b1;
                        if (w_bottle_inc == r_tgt_bottle)
                            w_state_nxt = S_REPORT;
                    end else begin
                        w_pill_nxt = w_pill_inc;
                    end
                end
            end
            S_PAUSE: begin
                if (!in_display_setting)
                    w_state_nxt = S_OPERATION;
            end
            S_REPORT: begin
                if (w_start_edge) begin
                    w_pill_nxt   = '0;
                    w_bottle_nxt = '0;
                    w_total_nxt  = '0;
                    w_state_nxt  = S_ZERO;
                end
            end
            default: w_state_nxt = S_ZERO;
        endcase
    end

    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            r_state      <= S_ZERO;
            r_prev_start <= 1'b0;
            r_prev_pill  <= 1'b0;
            r_tgt_bottle <= '0;
            r_tgt_pill   <= '0;
            r_pill       <= '0;
            r_bottle     <= '0;
            r_total      <= '0;
            r_change     <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_start <= in_start;
            r_prev_pill  <= in_pill_pulse;
            r_tgt_bottle <= w_tgt_bottle_nxt;
            r_tgt_pill   <= w_tgt_pill_nxt;
            r_pill       <= w_pill_nxt;
            r_bottle     <= w_bottle_nxt;
            r_total      <= w_total_nxt;
            r_change     <= w_change_nxt;
            r_alarm      <= w_alarm_nxt;
        end
    end

    assign out_state          = r_state;
    assign out_pill_in_bottle = r_pill;
    assign out_bottle_done    = r_bottle;
    assign out_total_pills    = r_total;
    assign out_bottle_change  = r_change;
    assign out_alarm          = r_alarm;

endmodule

// File: tb/tb_bottle_fill_control_module.sv
// Bench: random and directed stimulus against a run-total based reference model,
// plus literal checkpoints from hand-worked scenarios.
module tb_bottle_fill_control_module;

    localparam int CNT_W = 6;
    localparam int TOT_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pill = 1'b0;
    logic             setting = 1'b0;
    logic [CNT_W-1:0] tgt_b = '0;
    logic [CNT_W-1:0] tgt_p = '0;
    logic [1:0]       d_state;
    logic [CNT_W-1:0] d_pill;
    logic [CNT_W-1:0] d_bottle;
    logic [TOT_W-1:0] d_total;
    logic             d_change;
    logic             d_alarm;

    bottle_fill_control_module #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .in_CLK               (clk),
        .in_RST               (rst),
        .in_start             (start),
        .in_pill_pulse        (pill),
        .in_display_setting   (setting),
        .in_target_bottle_num (tgt_b),
        .in_target_pill_num   (tgt_p),
        .out_state            (d_state),
        .out_pill_in_bottle   (d_pill),
        .out_bottle_done      (d_bottle),
        .out_total_pills      (d_total),
        .out_bottle_change    (d_change),
        .out_alarm            (d_alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;
    int change_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the run is described by the total pill count; the
    // per-bottle and bottle counts follow from division by the pill target.
    int m_mode = 0;   // 0 zero, 1 operation, 2 pause, 3 report
    int m_total = 0;
    int m_tb = 0, m_tp = 0;
    bit m_change = 0, m_alarm = 0;
    bit m_ps = 0, m_pp = 0;

    always @(posedge clk) begin
        bit se, pe;
        se = start && !m_ps;
        pe = pill && !m_pp;
        m_ps = start;
        m_pp = pill;
        m_change = 0;
        if (rst) begin
            m_mode = 0; m_total = 0; m_tb = 0; m_tp = 0; m_alarm = 0;
            m_ps = 0; m_pp = 0;
        end else begin
            case (m_mode)
                0: if (se) begin
                    if (tgt_b != 0 && tgt_p != 0) begin
                        m_tb = int'(tgt_b); m_tp = int'(tgt_p);
                        m_total = 0; m_alarm = 0; m_mode = 1;
                    end else m_alarm = 1;
                end
                1: if (setting) m_mode = 2;
                   else if (pe) begin
                       m_total++;
                       if (m_total % m_tp == 0) m_change = 1;
                       if (m_total == m_tb * m_tp) m_mode = 3;
                   end
                2: if (!setting) m_mode = 1;
                default: if (se) begin m_total = 0; m_mode = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("state",  32'(d_state),  32'(m_mode));
            chk("pill",   32'(d_pill),   32'(m_tp == 0 ? 0 : m_total % m_tp));
            chk("bottle", 32'(d_bottle), 32'(m_tp == 0 ? 0 : m_total / m_tp));
            chk("total",  32'(d_total),  32'(m_total));
            chk("change", 32'(d_change), 32'(m_change));
            chk("alarm",  32'(d_alarm),  32'(m_alarm));
            if (d_change === 1'b1) change_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_pill();
        pill = 1'b1; cyc(1); pill = 1'b0; cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    endtask

    initial begin
        int base;
        cyc(2);
        check_en = 1'b1;
        rst = 1'b0;
        chk("rst_state", 32'(d_state), 0);
        chk("rst_total", 32'(d_total), 0);
        cyc(1);

        // Basic fill 2 bottles x 3 pills
        tgt_b = 6'd2; tgt_p = 6'd3;
        pulse_start();
        chk("run_state", 32'(d_state), 1);
        change_seen = 0;
        repeat (6) pulse_pill();
        chk("fill_state",  32'(d_state),  3);
        chk("fill_bottle", 32'(d_bottle), 2);
        chk("fill_pill",   32'(d_pill),   0);
        chk("fill_total",  32'(d_total),  6);
        chk("fill_strobes", 32'(change_seen), 2);

        // Report holds, then acknowledge, then new run
        repeat (3) pulse_pill();
        chk("rep_frozen", 32'(d_total), 6);
        pulse_start();
        chk("ack_state", 32'(d_state), 0);
        chk("ack_total", 32'(d_total), 0);
        pulse_start();
        chk("rerun_state", 32'(d_state), 1);

        // Reset mid-run after 1 bottle + 2 pills
        do_reset();
        tgt_b = 6'd3; tgt_p = 6'd4;
        pulse_start();
        repeat (6) pulse_pill();
        chk("mid_bottle", 32'(d_bottle), 1);
        chk("mid_pill",   32'(d_pill),   2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mrst_state", 32'(d_state), 0);
        chk("mrst_total", 32'(d_total), 0);
        chk("mrst_bottle", 32'(d_bottle), 0);
        cyc(1);

        // Zero target
        tgt_b = 6'd5; tgt_p = 6'd0;
        pulse_start();
        chk("zero_state", 32'(d_state), 0);
        chk("zero_alarm", 32'(d_alarm), 1);
        tgt_p = 6'd2;
        pulse_start();
        chk("zfix_state", 32'(d_state), 1);
        chk("zfix_alarm", 32'(d_alarm), 0);

        // Pause isolates settings
        do_reset();
        tgt_b = 6'd2; tgt_p = 6'd5;
        pulse_start();
        repeat (2) pulse_pill();
        setting = 1'b1; cyc(1);
        repeat (3) pulse_pill();
        chk("pause_state", 32'(d_state), 2);
        chk("pause_pill",  32'(d_pill),  2);
        tgt_p = 6'd9;
        setting = 1'b0; cyc(1);
        chk("resume_state", 32'(d_state), 1);
        repeat (3) pulse_pill();
        chk("p5_bottle", 32'(d_bottle), 1);
        chk("p5_pill",   32'(d_pill),   0);

        // Held pill level counts once
        base = int'(d_total);
        pill = 1'b1; cyc(10); pill = 1'b0; cyc(1);
        chk("hold_once", 32'(d_total), 32'(base + 1));

        // Coincident start and pill in zero state
        do_reset();
        tgt_b = 6'd2; tgt_p = 6'd2;
        start = 1'b1; pill = 1'b1; cyc(1); start = 1'b0; pill = 1'b0; cyc(1);
        chk("coin_state", 32'(d_state), 1);
        chk("coin_total", 32'(d_total), 0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            pill  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 29) == 0) setting = ~setting;
            if ($urandom_range(0, 39) == 0) tgt_b = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) tgt_p = CNT_W'($urandom_range(0, 4));
            cyc(1);
        end
        rst = 1'b0; start = 1'b0; pill = 1'b0; setting = 1'b0;
        cyc(2);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
